// File: rtl/qsn_pipe_pkg.sv
// Shared configuration for the LDPC quasi-cyclic shift network.
package configs;
  localparam int DWIDTH        = 8;
  localparam int LiftingFactor = 8;
  localparam int SEL           = $clog2(LiftingFactor);
  localparam int ZW            = SEL + 1;
  localparam int TAGW          = 4;

  typedef logic [DWIDTH-1:0] qsn_vec_t [LiftingFactor];
endpackage

// File: rtl/qsn_pipe_if.sv
// Beat bus of the shift network: input side and output side handshakes.
interface qsn_pipe_if
  import configs::*;
#(
  parameter int DWIDTH        = configs::DWIDTH,
  parameter int LiftingFactor = configs::LiftingFactor,
  parameter int SEL           = configs::SEL,
  parameter int ZW            = SEL + 1,
  parameter int TAGW          = configs::TAGW
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data [LiftingFactor];
  logic [SEL-1:0]    in_shift;
  logic [ZW-1:0]     in_z;
  logic              in_inv;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data [LiftingFactor];
  logic [TAGW-1:0]   out_tag;
  logic              out_err;

  modport slave (
    input  in_valid, in_data, in_shift, in_z, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

  modport master (
    output in_valid, in_data, in_shift, in_z, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/qsn_modz_rot.sv
// Combinational rotator: lane i takes lane (i + r) mod z; lanes >= z are zero.
// An error beat passes through untouched.
module qsn_modz_rot
  import configs::*;
#(
  parameter int DWIDTH        = configs::DWIDTH,
  parameter int LiftingFactor = configs::LiftingFactor,
  parameter int SEL           = configs::SEL,
  parameter int ZW            = SEL + 1
) (
  input  logic [DWIDTH-1:0] vec [LiftingFactor],
  input  logic [SEL-1:0]    r,
  input  logic [ZW-1:0]     z,
  input  logic              err,
  output logic [DWIDTH-1:0] rot [LiftingFactor]
);
  logic [ZW-1:0] idx;

  // i + r stays below 2z, so one conditional subtract gives the mod-z index
  always_comb begin
    idx = '0;
    for (int i = 0; i < LiftingFactor; i++) begin
      idx = ZW'(i) + ZW'(r);
      if (idx >= z) idx = idx - z;
      if (err)              rot[i] = vec[i];
      else if (ZW'(i) < z)  rot[i] = vec[idx[SEL-1:0]];
      else                  rot[i] = '0;
    end
  end
endmodule

// File: rtl/qsn_pipe.sv
// Two-stage registered quasi-cyclic shift network with valid/ready backpressure.
// Stage A normalises the rotation, stage B holds the rotated lanes.
module qsn_pipe
  import configs::*;
#(
  parameter int DWIDTH        = configs::DWIDTH,
  parameter int LiftingFactor = configs::LiftingFactor,
  parameter int SEL           = configs::SEL,
  parameter int ZW            = SEL + 1,
  parameter int TAGW          = 4
) (
  input logic        clk,
  input logic        rst,
  qsn_pipe_if.slave  bus
);
  logic              vld_p0, vld_p1;
  logic              adv_p0, adv_p1;
  logic [DWIDTH-1:0] data_p0 [LiftingFactor];
  logic [DWIDTH-1:0] rot_p0  [LiftingFactor];
  logic [DWIDTH-1:0] data_p1 [LiftingFactor];
  logic [TAGW-1:0]   tag_p0, tag_p1;
  logic [ZW-1:0]     z_p0;
  logic [SEL-1:0]    r_p0;
  logic              err_p0, err_p1;
  logic              err_in;

  function automatic logic beat_err(input logic [ZW-1:0] z, input logic [SEL-1:0] s);
    return (z == '0) || (z > ZW'(LiftingFactor)) || (ZW'(s) >= z);
  endfunction

  // Inverse rotation by s equals forward rotation by z - s (0 stays 0)
  function automatic logic [SEL-1:0] norm_rot(input logic [ZW-1:0] z, input logic [SEL-1:0] s,
                                              input logic inv, input logic err);
    logic [ZW-1:0] d;
    d = z - ZW'(s);
    if (err)       return '0;
    if (!inv)      return s;
    if (s == '0)   return '0;
    return d[SEL-1:0];
  endfunction

  assign err_in       = beat_err(bus.in_z, bus.in_shift);
  assign adv_p1       = !vld_p1 || bus.out_ready;
  assign adv_p0       = !vld_p0 || adv_p1;
  assign bus.in_ready = !rst && adv_p0;

  // ---- stage A: capture beat and normalised rotation
  // Stage A occupancy
  always_ff @(posedge clk) begin
    if (rst)         vld_p0 <= 1'b0;
    else if (adv_p0) vld_p0 <= bus.in_valid;
  end

  // Stage A payload, loaded only on an accepted beat
  always_ff @(posedge clk) begin
    if (adv_p0 && bus.in_valid) begin
      data_p0 <= bus.in_data;
      tag_p0  <= bus.in_tag;
      z_p0    <= bus.in_z;
      err_p0  <= err_in;
      r_p0    <= norm_rot(bus.in_z, bus.in_shift, bus.in_inv, err_in);
    end
  end

  qsn_modz_rot #(
    .DWIDTH(DWIDTH), .LiftingFactor(LiftingFactor), .SEL(SEL), .ZW(ZW)
  ) u_rot (
    .vec(data_p0), .r(r_p0), .z(z_p0), .err(err_p0), .rot(rot_p0)
  );

  // ---- stage B: rotated lanes, held while downstream stalls
  // Stage B occupancy and output payload; outputs read zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '{default: '0};
      tag_p1  <= '0;
      err_p1  <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= rot_p0;
        tag_p1  <= tag_p0;
        err_p1  <= err_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_tag   = tag_p1;
  assign bus.out_err   = err_p1;
endmodule

// File: doc/qsn_pipe.md
# qsn_pipe

Pipelined, runtime-configurable quasi-cyclic shift network for the LDPC datapath. It rotates one block of `LiftingFactor` lanes, each `DWIDTH` wide, by a per-beat shift within an active lifting size `z`. It supports forward and inverse rotation, carries a sideband tag, and uses a valid/ready handshake with full backpressure. It sits between the message memories and the check-node units, and is the registered, multi-`z` successor of the single-size combinational shift network.

## Interface
Parameters:
- `DWIDTH`, default `configs::DWIDTH`: lane width in bits.
- `LiftingFactor`, default `configs::LiftingFactor`: maximum lifting size, i.e. the lane count.
- `SEL`, default `configs::SEL` (= `$clog2(LiftingFactor)`): shift width.
- `ZW`, default `SEL+1`: width of the `z` field.
- `TAGW`, default 4: sideband tag width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when high together with `in_valid`.
- `in_data`  in  `DWIDTH` x `LiftingFactor` (unpacked)  input lanes.
- `in_shift`  in  `SEL`  rotation amount; legal range 0..z-1.
- `in_z`  in  `ZW`  active lifting size; legal range 1..`LiftingFactor`.
- `in_inv`  in  1  1 selects inverse rotation.
- `in_tag`  in  `TAGW`  sideband, passed through unchanged.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `DWIDTH` x `LiftingFactor`  rotated lanes.
- `out_tag`  out  `TAGW`  tag of the beat.
- `out_err`  out  1  illegal `z`/shift detected for this beat.

## Operation
- A beat is accepted when `in_valid && in_ready`. The pipeline has two register stages, A and B.
- Stage A captures data, tag, `z`, the error flag and the normalised rotation `r`:
  - `err = (in_z == 0) || (in_z > LiftingFactor) || (in_shift >= in_z)`.
  - `r = in_inv ? (in_shift == 0 ? 0 : in_z - in_shift) : in_shift`.
  - When `err` is set, `r` is forced to 0.
- Stage B computes the output lanes.
  - No error: for i < z, `out[i] = A[(i + r) mod z]`. Because i + r < 2z, the modulo is a single conditional subtract of z. For i >= z, `out[i] = 0`.
  - Error: identity on all `LiftingFactor` lanes, with `out_err = 1`.
- Forward then inverse with the same (`z`, shift) returns the original lanes 0..z-1.
- Tags and beats leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: 2 cycles from the accept edge to `out_valid` with no stall. Throughput is 1 beat per cycle.
- Stall rule: a stage advances when its successor is empty or advancing.
  - `in_ready = !vA || !vB || out_ready`.
  - `in_ready` is combinational from `out_ready`.
- While `out_valid && !out_ready`, `out_data`, `out_tag` and `out_err` hold stable. `out_valid` never falls without a handshake.
- Reset (sync, active-high):
  - `out_valid`, `out_data`, `out_tag`, `out_err` are 0.
  - Internal valids are 0.
  - `in_ready` is 0 during any cycle with `rst` high.
- Reset mid-operation: all in-flight beats are discarded. No output is produced for them, and `out_valid` is 0 on the cycle after the reset edge.
- Accept and emit in the same cycle on a full pipe is legal, with no bubble.

## Structure
- Package `configs`: `DWIDTH`, `LiftingFactor`, `SEL`, and the new `ZW`, `TAGW` and `typedef logic [DWIDTH-1:0] qsn_vec_t [LiftingFactor]`.
- Sub-module `qsn_modz_rot`: a purely combinational mod-z rotator with inputs (vector, `r`, `z`, `err`) and output vector. It is instantiated between stage A and stage B. The handshake and registers live in `qsn_pipe`.

## Test plan
All scenarios use `LiftingFactor` = 8, `DWIDTH` = 8, and input lanes = 0..7.
1. `z` = 8, shift = 3, inv = 0 -> `out` = 3,4,5,6,7,0,1,2, `err` = 0, `out_valid` 2 cycles after accept.
2. `z` = 5, shift = 2, inv = 0 -> `out` = 2,3,4,0,1,0,0,0.
3. `z` = 5, shift = 2, inv = 1 -> `out` = 3,4,0,1,2,0,0,0. Feeding the case-2 output back with inv = 1 returns 0,1,2,3,4,0,0,0.
4. Illegal inputs -> `out_err` = 1, `out` = 0..7:
   - `z` = 5, shift = 5.
   - `z` = 0, shift = 0.
   - `z` = 9.
5. Four back-to-back beats with tags 0..3, `out_ready` low for 2 cycles after the first output -> `in_ready` drops once both stages are full, outputs are held stable, and tags emerge as 0,1,2,3 with no loss or duplication.
6. Two beats in flight, `rst` high for 1 cycle -> `out_valid` = 0 the next cycle and no output for either beat. A new beat accepted after reset emerges normally 2 cycles later.
